// File: rtl/aes_round_sequencer_pkg.sv
// Shared types and round-count helpers for the iterative AES block engine controller.
package aes_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDKEY,
        ST_ROUND,
        ST_DONE
    } aes_seq_state_e;

    localparam int AES_NR128 = 10;
    localparam int AES_NR192 = 12;
    localparam int AES_NR256 = 14;

    // Zero marks an unsupported key length.
    function automatic int aes_nr(input int key_bits);
        case (key_bits)
            128:     return AES_NR128;
            192:     return AES_NR192;
            256:     return AES_NR256;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES round sequencer: one-deep input buffer, ADDKEY + NR rounds, push under backpressure.
// Build option AES_SEQ_PREFETCH_EN: accept the next block while the current one is in flight.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    input  logic              in_encrypt,
    output logic [ADDR_W-1:0] rk_addr,
    input  logic [127:0]      rk_data,
    output logic [127:0]      rnd_in,
    output logic              rnd_encrypt,
    output logic              rnd_last,
    input  logic [127:0]      rnd_out,
    input  logic              tx_fifo_full,
    output logic              tx_push,
    output logic [127:0]      tx_fifo_in,
    output logic              data_done,
    output logic              busy
);

    localparam int NR = aes_nr(KEY_BITS);
    localparam logic [ADDR_W-1:0] NR_A = ADDR_W'(NR);

    if (NR == 0) begin : g_bad_key_bits
        $error("aes_round_sequencer: unsupported KEY_BITS=%0d", KEY_BITS);
    end
    if ((2 ** ADDR_W) <= NR) begin : g_bad_addr_w
        $error("aes_round_sequencer: ADDR_W=%0d too narrow for NR=%0d", ADDR_W, NR);
    end

    aes_seq_state_e    state;
    aes_block_t        in_buf;
    aes_block_t        state_reg;
    logic              buf_mode;
    logic              buf_full;
    logic              cur_mode;
    logic [ADDR_W-1:0] rcnt;
    logic              handshake;
    logic              push;

    always_comb begin
`ifdef AES_SEQ_PREFETCH_EN
        in_ready = !rst && !buf_full;
`else
        in_ready = !rst && (state == ST_IDLE) && !buf_full;
`endif
        push      = !rst && (state == ST_DONE) && !tx_fifo_full;
        handshake = in_valid && in_ready;
    end

    assign tx_push     = push;
    assign data_done   = push;
    assign busy        = !rst && ((state != ST_IDLE) || buf_full);
    assign rnd_in      = state_reg;
    assign rnd_encrypt = cur_mode;
    assign rnd_last    = !rst && (state == ST_ROUND) && (rcnt == NR_A);
    assign tx_fifo_in  = rst ? '0 : state_reg;

    // Decryption walks the key schedule backwards from NR.
    always_comb begin
        rk_addr = '0;
        if (!rst) begin
            case (state)
                ST_ADDKEY: rk_addr = buf_mode ? '0 : NR_A;
                ST_ROUND:  rk_addr = cur_mode ? rcnt : NR_A - rcnt;
                default:   rk_addr = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_buf    <= '0;
            buf_mode  <= 1'b0;
            buf_full  <= 1'b0;
            cur_mode  <= 1'b0;
            state_reg <= '0;
            rcnt      <= '0;
        end else begin
            if (handshake) begin
                in_buf   <= in_data;
                buf_mode <= in_encrypt;
            end
            if (state == ST_ADDKEY) begin
                buf_full <= 1'b0;
            end
            if (handshake) begin
                buf_full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (handshake || buf_full) begin
                        state <= ST_ADDKEY;
                    end
                end
                ST_ADDKEY: begin
                    state_reg <= in_buf ^ rk_data;
                    cur_mode  <= buf_mode;
                    rcnt      <= ADDR_W'(1);
                    state     <= ST_ROUND;
                end
                ST_ROUND: begin
                    state_reg <= rnd_out;
                    if (rcnt == NR_A) begin
                        state <= ST_DONE;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // A block taken in the push cycle is chained directly, as if already buffered.
                    if (push) begin
                        state <= (buf_full || handshake) ? ST_ADDKEY : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: AES-128 and AES-256 instances with a behavioural round unit.
module tb_aes_round_sequencer;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_SEQ_PREFETCH_EN
    localparam int GAP = 12;
`else
    localparam int GAP = 13;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic         a_in_valid, a_in_ready, a_in_encrypt, a_rnd_encrypt, a_rnd_last;
    logic         a_full, a_tx_push, a_data_done, a_busy;
    logic [4:0]   a_rk_addr;
    logic [127:0] a_in_data, a_rk_data, a_rnd_in, a_rnd_out, a_tx_fifo_in;
    logic         b_in_valid, b_in_ready, b_in_encrypt, b_rnd_encrypt, b_rnd_last;
    logic         b_full, b_tx_push, b_data_done, b_busy;
    logic [4:0]   b_rk_addr;
    logic [127:0] b_in_data, b_rk_data, b_rnd_in, b_rnd_out, b_tx_fifo_in;

    logic [127:0] rk128 [0:31];
    logic [127:0] rk256 [0:31];
    logic [127:0] a_push_q [$];
    int           a_push_t [$];

    aes_round_sequencer #(.KEY_BITS(128), .ADDR_W(5)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_encrypt(a_in_encrypt), .rk_addr(a_rk_addr),
        .rk_data(a_rk_data), .rnd_in(a_rnd_in), .rnd_encrypt(a_rnd_encrypt),
        .rnd_last(a_rnd_last), .rnd_out(a_rnd_out), .tx_fifo_full(a_full),
        .tx_push(a_tx_push), .tx_fifo_in(a_tx_fifo_in), .data_done(a_data_done),
        .busy(a_busy)
    );

    aes_round_sequencer #(.KEY_BITS(256), .ADDR_W(5)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_encrypt(b_in_encrypt), .rk_addr(b_rk_addr),
        .rk_data(b_rk_data), .rnd_in(b_rnd_in), .rnd_encrypt(b_rnd_encrypt),
        .rnd_last(b_rnd_last), .rnd_out(b_rnd_out), .tx_fifo_full(b_full),
        .tx_push(b_tx_push), .tx_fifo_in(b_tx_fifo_in), .data_done(b_data_done),
        .busy(b_busy)
    );

    // GF(2^8) arithmetic; the S-box is derived from the field inverse and affine map.
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h00;
        q = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ q;
            q = xt(q);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x};
        return t[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = ginv(x);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k,
                                             input logic enc, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   m [4];
        logic [7:0]   cf [4];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int rr = 0; rr < 4; rr++) begin
            for (int c = 0; c < 4; c++) begin
                if (enc) b[rr+4*c] = sbox(a[rr+4*((c+rr)%4)]);
                else     b[rr+4*c] = inv_sbox(a[rr+4*((c-rr+4)%4)]);
            end
        end
        if (enc) begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end else begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
            for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
        end
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                for (int rr = 0; rr < 4; rr++) begin
                    m[rr] = 8'h00;
                    for (int j = 0; j < 4; j++) m[rr] = m[rr] ^ gmul(cf[(j-rr+4)%4], b[j+4*c]);
                end
                for (int rr = 0; rr < 4; rr++) b[rr+4*c] = m[rr];
            end
        end
        if (enc) begin
            for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    assign a_rk_data = rk128[a_rk_addr];
    assign b_rk_data = rk256[b_rk_addr];
    always_comb a_rnd_out = aes_rnd(a_rnd_in, a_rk_data, a_rnd_encrypt, a_rnd_last);
    always_comb b_rnd_out = aes_rnd(b_rnd_in, b_rk_data, b_rnd_encrypt, b_rnd_last);

    always @(posedge clk) begin
        if (a_tx_push) begin
            a_push_q.push_back(a_tx_fifo_in);
            a_push_t.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic expand_keys();
        logic [31:0]  w [0:59];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] v;
        int nk;
        int nw;
        for (int kb = 0; kb < 2; kb++) begin
            nk = (kb == 0) ? 4 : 8;
            nw = 4 * (nk + 7);
            rc = 8'h01;
            for (int i = 0; i < nw; i++) begin
                if (i < nk) begin
                    w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
                end else begin
                    t = w[i-1];
                    if (i % nk == 0) begin
                        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                        rc = xt(rc);
                    end else if (nk > 6 && i % nk == 4) begin
                        t = subw(t);
                    end
                    w[i] = w[i-nk] ^ t;
                end
            end
            for (int r = 0; r < 32; r++) begin
                v = '0;
                if (4*r+3 < nw) v = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
                if (kb == 0) rk128[r] = v;
                else         rk256[r] = v;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic a_run(input logic [127:0] din, input logic enc, input logic [127:0] exp,
                         input int hold, input bit toggle);
        int t0;
        chk("a_ready_idle", a_in_ready, 1);
        a_in_valid = 1'b1; a_in_data = din; a_in_encrypt = enc;
        t0 = cyc;
        step();
        a_in_valid = 1'b0; a_in_data = '0;
        chk("a_addkey_addr", a_rk_addr, enc ? 0 : 10);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (toggle) a_in_encrypt = ~a_in_encrypt;
            chk("a_round_addr", a_rk_addr, enc ? i : 10 - i);
            chk("a_round_last", a_rnd_last, i == 10);
            chk("a_round_mode", a_rnd_encrypt, enc);
            chk("a_round_nopush", a_tx_push, 0);
        end
        if (hold > 0) a_full = 1'b1;
        for (int k = 0; k < hold; k++) begin
            step();
            chk("a_full_nopush", a_tx_push, 0);
            chk("a_full_stable", a_tx_fifo_in, exp);
        end
        step();
        a_full = 1'b0;
        #1;
        chk("a_push", a_tx_push, 1);
        chk("a_done", a_data_done, 1);
        chk("a_result", a_tx_fifo_in, exp);
        chk("a_latency", cyc - t0, 12 + hold);
        step();
        chk("a_push_once", a_tx_push, 0);
        chk("a_done_once", a_data_done, 0);
        chk("a_idle_busy", a_busy, 0);
    endtask

    initial begin
        int t0;
        int n0;
        int nh;
        a_in_valid = 1'b0; a_in_data = '0; a_in_encrypt = 1'b0; a_full = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_encrypt = 1'b0; b_full = 1'b0;
        expand_keys();
        step();
        step();
        chk("rst_a_ready", a_in_ready, 0);
        chk("rst_a_push", a_tx_push, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_addr", a_rk_addr, 0);
        chk("rst_a_txin", a_tx_fifo_in, 0);
        chk("rst_b_ready", b_in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rel_a_ready", a_in_ready, 1);
        chk("rel_b_ready", b_in_ready, 1);

        a_run(PT, 1'b1, CT128, 0, 1'b0);
        a_run(CT128, 1'b0, PT, 0, 1'b0);

        b_in_valid = 1'b1; b_in_data = PT; b_in_encrypt = 1'b1;
        t0 = cyc;
        step();
        b_in_valid = 1'b0;
        chk("b_addkey_addr", b_rk_addr, 0);
        for (int i = 1; i <= 14; i++) begin
            step();
            chk("b_round_addr", b_rk_addr, i);
            chk("b_round_last", b_rnd_last, i == 14);
            chk("b_round_nopush", b_tx_push, 0);
        end
        step();
        chk("b_push", b_tx_push, 1);
        chk("b_result", b_tx_fifo_in, CT256);
        chk("b_latency", cyc - t0, 16);
        step();
        chk("b_push_once", b_tx_push, 0);

        a_run(PT, 1'b1, CT128, 5, 1'b1);

        a_in_valid = 1'b1; a_in_data = PT; a_in_encrypt = 1'b1;
        step();
        a_in_valid = 1'b0;
        repeat (5) step();
        chk("r_addr_rcnt5", a_rk_addr, 5);
        n0 = a_push_q.size();
        rst = 1'b1;
        #1;
        chk("r_ready", a_in_ready, 0);
        chk("r_push", a_tx_push, 0);
        chk("r_done", a_data_done, 0);
        chk("r_busy", a_busy, 0);
        chk("r_addr", a_rk_addr, 0);
        chk("r_txin", a_tx_fifo_in, 0);
        chk("r_last", a_rnd_last, 0);
        step();
        chk("r2_busy", a_busy, 0);
        chk("r2_txin", a_tx_fifo_in, 0);
        rst = 1'b0;
        #1;
        chk("r_rel_ready", a_in_ready, 1);
        chk("r_rel_busy", a_busy, 0);
        repeat (20) step();
        chk("r_no_push", a_push_q.size(), n0);

        nh = 0;
        n0 = a_push_q.size();
        a_in_valid = 1'b1; a_in_data = PT; a_in_encrypt = 1'b1;
        for (int c = 0; c < 60 && nh < 2; c++) begin
            if (a_in_ready) nh++;
            step();
        end
        a_in_valid = 1'b0;
        chk("b2b_handshakes", nh, 2);
        for (int c = 0; c < 60 && a_push_q.size() < n0 + 2; c++) step();
        chk("b2b_pushes", a_push_q.size(), n0 + 2);
        if (a_push_q.size() >= n0 + 2) begin
            chk("b2b_gap", a_push_t[n0+1] - a_push_t[n0], GAP);
            chk("b2b_data0", a_push_q[n0], CT128);
            chk("b2b_data1", a_push_q[n0+1], CT128);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
